// File: rtl/cello_lut_eval_pipe_if.sv
// cello_lut_eval_pipe_if: vector, result and config-load handshakes of the LUT evaluation pipeline
interface cello_lut_eval_pipe_if #(
  parameter int N_IN = 4,
  parameter int NUM_CH = 2,
  parameter int CFG_W = 4
);
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic in_valid;
  logic in_ready;
  logic [NUM_CH*N_IN-1:0] in_vec;
  logic out_valid;
  logic out_ready;
  logic [NUM_CH-1:0] out_vec;
  logic cfg_valid;
  logic cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CFG_W-1:0] cfg_data;
  logic cfg_done;
  modport master (
    output in_valid, in_vec, out_ready, cfg_valid, cfg_ch, cfg_data,
    input in_ready, out_valid, out_vec, cfg_ready, cfg_done
  );
  modport slave (
    input in_valid, in_vec, out_ready, cfg_valid, cfg_ch, cfg_data,
    output in_ready, out_valid, out_vec, cfg_ready, cfg_done
  );
endinterface

// File: rtl/cello_lut_eval_pipe.sv
// cello_lut_eval_pipe: NUM_CH truth-table lookups through a stallable LAT-stage pipeline,
// with tables reloaded through a chunked shadow register and committed atomically.
module cello_lut_eval_pipe #(
  parameter int N_IN = 4,
  parameter int NUM_CH = 2,
  parameter int LAT = 3,
  parameter int CFG_W = 4,
  parameter logic [(1<<N_IN)-1:0] TT_INIT = 16'hC766
) (
  input logic clk,
  input logic rst,
  cello_lut_eval_pipe_if.slave io
);
  localparam int TW = 1 << N_IN;
  localparam int BEATS = TW / CFG_W;
  localparam int CHW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int BW = $clog2(BEATS + 1);
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
  state_t st;
  logic [TW-1:0] tt [NUM_CH];
  logic [TW-1:0] shadow;
  logic [CHW-1:0] ch;
  logic [BW-1:0] beat_cnt;
  logic [LAT-1:0] v;
  logic [LAT-1:0] en;
  logic [NUM_CH-1:0] d [LAT];
  logic [NUM_CH-1:0] lut;
  logic e;
  // a stage may load when it is empty or everything downstream of it moves
  always_comb begin
    en = '0;
    e = io.out_ready;
    for (int k = LAT - 1; k >= 0; k--) begin
      e = !v[k] || e;
      en[k] = e;
    end
  end
  // row 0 is the table MSB, so the bit index is the bitwise complement of idx
  always_comb begin
    lut = '0;
    for (int c = 0; c < NUM_CH; c++) lut[c] = tt[c][~io.in_vec[c*N_IN +: N_IN]];
  end
  assign io.in_ready = en[0];
  assign io.out_valid = v[LAT-1];
  assign io.out_vec = d[LAT-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int k = 0; k < LAT; k++) d[k] <= '0;
    end else begin
      if (en[0]) begin
        v[0] <= io.in_valid;
        d[0] <= lut;
      end
      for (int k = 1; k < LAT; k++) begin
        if (en[k]) begin
          v[k] <= v[k-1];
          d[k] <= d[k-1];
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      io.cfg_ready <= 1'b1;
      io.cfg_done <= 1'b0;
      beat_cnt <= '0;
      shadow <= '0;
      ch <= '0;
      for (int c = 0; c < NUM_CH; c++) tt[c] <= TT_INIT;
    end else begin
      io.cfg_done <= 1'b0;
      if (st == COMMIT) begin
        for (int c = 0; c < NUM_CH; c++) if (ch == CHW'(c)) tt[c] <= shadow;
        st <= IDLE;
        io.cfg_ready <= 1'b1;
        beat_cnt <= '0;
      end else if (io.cfg_valid) begin
        shadow <= (shadow << CFG_W) | TW'(io.cfg_data);
        beat_cnt <= beat_cnt + 1'b1;
        if (st == IDLE) ch <= io.cfg_ch;
        if (beat_cnt == BW'(BEATS - 1)) begin
          st <= COMMIT;
          io.cfg_ready <= 1'b0;
          io.cfg_done <= 1'b1;
        end else begin
          st <= LOAD;
        end
      end
    end
  end
endmodule

// File: tb/tb_cello_lut_eval_pipe.sv
// tb_cello_lut_eval_pipe: directed stimulus with a scoreboard of expected lookups and commits
module tb_cello_lut_eval_pipe;
  localparam int LAT = 3;
  typedef struct {logic [1:0] v; int t;} ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int nchk = 0, npass = 0, cyc = 0, waits = 0, ndone = 0, mbeat = 0;
  logic lat_chk = 1'b0;
  logic mpend = 1'b0;
  logic mch = 1'b0;
  logic [15:0] msh = '0;
  logic [15:0] mt [2];
  ent_t q[$];
  cello_lut_eval_pipe_if #(.N_IN(4), .NUM_CH(2), .CFG_W(4)) io ();
  cello_lut_eval_pipe #(.N_IN(4), .NUM_CH(2), .LAT(LAT), .CFG_W(4), .TT_INIT(16'hC766)) dut (
    .clk(clk), .rst(rst), .io(io)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [1:0] lk(input logic [7:0] iv);
    lk[0] = mt[0][15 - iv[3:0]];
    lk[1] = mt[1][15 - iv[7:4]];
  endfunction
  task automatic tally(input bit ok, input string tag);
    nchk++;
    if (ok) npass++;
    else $error("FAIL %s", tag);
  endtask
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mbeat = 0;
      mpend = 1'b0;
      msh = '0;
      mt[0] = 16'hC766;
      mt[1] = 16'hC766;
    end else begin
      if (io.out_valid && io.out_ready) begin
        if (q.size() == 0) begin
          tally(q.size() === 1, "sb_underflow");
        end else begin
          ent_t e;
          e = q.pop_front();
          tally(io.out_vec === e.v, "out_vec");
          if (lat_chk) tally((cyc - e.t) === LAT, "latency");
        end
      end
      if (io.in_valid && io.in_ready) q.push_back('{lk(io.in_vec), cyc});
      tally(io.cfg_done === mpend, "cfg_done");
      if (io.cfg_done) ndone++;
      if (mpend) begin
        mt[mch] = msh;
        mpend = 1'b0;
      end
      if (io.cfg_valid && io.cfg_ready) begin
        if (mbeat == 0) mch = io.cfg_ch;
        msh = {msh[11:0], io.cfg_data};
        mbeat++;
        if (mbeat == 4) begin
          mbeat = 0;
          mpend = 1'b1;
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] a0, input logic [3:0] a1);
    io.in_vec = {a1, a0};
    io.in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!io.in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    tally(io.in_ready === 1'b1, "send_accept");
    step();
  endtask
  task automatic idle();
    io.in_valid = 1'b0;
  endtask
  task automatic cfg_beat(input logic [3:0] data, input logic ch);
    int n = 0;
    io.cfg_valid = 1'b1;
    io.cfg_data = data;
    io.cfg_ch = ch;
    @(negedge clk);
    while (!io.cfg_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    tally(io.cfg_ready === 1'b1, "cfg_accept");
    step();
    io.cfg_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tally(q.size() === 0, "drain");
    step();
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int d0;
    io.in_valid = 1'b0;
    io.in_vec = '0;
    io.out_ready = 1'b1;
    io.cfg_valid = 1'b0;
    io.cfg_ch = '0;
    io.cfg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    tally(io.in_ready === 1'b1, "rst_in_ready");
    tally(io.cfg_ready === 1'b1, "rst_cfg_ready");
    tally(io.out_valid === 1'b0, "rst_out_valid");
    tally(io.out_vec === 2'b00, "rst_out_vec");
    tally(io.cfg_done === 1'b0, "rst_cfg_done");
    step();
    lat_chk = 1'b1;
    send(4'd0, 4'd0);
    send(4'd2, 4'd0);
    send(4'd4, 4'd0);
    send(4'd6, 4'd0);
    idle();
    drain();
    for (int i = 0; i < 16; i++) begin
      send(4'(i), 4'(15 - i));
      tally(waits === 0, "t2_rate");
    end
    idle();
    drain();
    lat_chk = 1'b0;
    io.out_ready = 1'b0;
    send(4'd1, 4'd3);
    send(4'd2, 4'd9);
    send(4'd7, 4'd13);
    io.in_vec = {4'd5, 4'd11};
    io.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tally(io.in_ready === 1'b0, "t3_in_ready");
      tally(io.out_valid === 1'b1, "t3_out_valid");
      tally(io.out_vec === q[0].v, "t3_stable");
      tally(q.size() === 3, "t3_depth");
    end
    step();
    io.out_ready = 1'b1;
    send(4'd11, 4'd5);
    idle();
    drain();
    d0 = ndone;
    cfg_beat(4'h8, 1'b1);
    repeat (2) step();
    cfg_beat(4'h0, 1'b1);
    repeat (2) step();
    cfg_beat(4'h0, 1'b1);
    repeat (2) step();
    cfg_beat(4'h0, 1'b1);
    repeat (3) step();
    tally(ndone === d0 + 1, "t4_done_once");
    send(4'd0, 4'd0);
    send(4'd0, 4'd1);
    send(4'd0, 4'd15);
    send(4'd0, 4'd6);
    idle();
    drain();
    cfg_beat(4'hF, 1'b0);
    cfg_beat(4'hF, 1'b0);
    cfg_beat(4'hF, 1'b0);
    cfg_beat(4'hF, 1'b0);
    io.in_vec = {4'd0, 4'd2};
    io.in_valid = 1'b1;
    @(negedge clk);
    tally(io.cfg_done === 1'b1, "t5_commit_cycle");
    tally(io.in_ready === 1'b1, "t5_accept_cycle");
    tally(q[q.size()-1].v[0] === 1'b0, "t5_old_row2");
    step();
    send(4'd2, 4'd0);
    idle();
    drain();
    tally(mt[0][13] === 1'b1, "t5_new_row2");
    d0 = ndone;
    io.out_ready = 1'b0;
    cfg_beat(4'h0, 1'b0);
    cfg_beat(4'h0, 1'b0);
    send(4'd3, 4'd3);
    send(4'd4, 4'd4);
    idle();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    io.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tally(io.out_valid === 1'b0, "t6_out_valid");
      tally(io.out_vec === 2'b00, "t6_out_vec");
      tally(io.cfg_ready === 1'b1, "t6_cfg_ready");
    end
    tally(ndone === d0, "t6_no_done");
    step();
    for (int i = 0; i < 16; i++) send(4'(i), 4'(i));
    idle();
    drain();
    tally(q.size() === 0, "sb_empty");
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
